pulse_sched: RTL and testbench
==============================

Name: pulse_sched

Overview:
Round-robin scheduler that shares one pulse_gen instance between N_CH requesters.
- Each requester asks for a burst of B pulse periods with its own period and LOW-transition values.
- The scheduler grants one channel, latches its config, and drives pulse_gen's start/cntr_max/cntr_low.
- It counts pulse_gen start_strobe pulses, releases start after the B-th, waits for pulse_gen busy to fall, then signals done.
- Sits in the Peripheral_Unit between the register/bus front-end and pulse_gen.

Parameters:
- N_CH, 4, number of requesting channels (2..8)
- CNTR_WIDTH, 32, must equal the connected pulse_gen CNTR_WIDTH
- BURST_WIDTH, 8, width of per-channel burst count

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  global enable; when low, all state and outputs hold
- req  in  N_CH  level request per channel
- ch_cntr_max  in  N_CH*CNTR_WIDTH  per-channel period value, packed channel 0 at LSBs
- ch_cntr_low  in  N_CH*CNTR_WIDTH  per-channel LOW-transition value, packed
- ch_burst  in  N_CH*BURST_WIDTH  per-channel number of periods, packed
- gnt  out  N_CH  one-hot owner of pulse_gen; all-zero when idle
- done  out  N_CH  one-cycle completion strobe for the owning channel
- err  out  1  one-cycle strobe coincident with done when the request was rejected
- pg_start  out  1  to pulse_gen start
- pg_cntr_max  out  CNTR_WIDTH  to pulse_gen cntr_max
- pg_cntr_low  out  CNTR_WIDTH  to pulse_gen cntr_low
- pg_start_strobe  in  1  from pulse_gen start_strobe
- pg_busy  in  1  from pulse_gen busy
- sched_busy  out  1  high in any state other than IDLE

Behaviour:
Reset (async, nrst low):
- All outputs = 0; state = IDLE; rr_ptr = 0; burst counter = 0; latched config = 0.
- Reset asserted mid-burst aborts immediately: pg_start drops to 0 at once and no done is issued.

en low: all registers hold; outputs stay registered at their current values.

State machine, all outputs registered:
- IDLE
  - If any req is set, select a winner by round-robin: the first set req scanning from rr_ptr upward, wrapping at N_CH.
  - Latch the winner's cntr_max, cntr_low and burst.
  - Set gnt one-hot and move to CHECK.
- CHECK
  - If latched burst == 0 or latched cntr_max == 0: pulse done[owner] and err for 1 cycle, clear gnt, go to IDLE.
  - Otherwise: drive pg_cntr_max/pg_cntr_low from the latches, set pg_start = 1, clear the strobe count, go to RUN.
- RUN
  - Each pg_start_strobe increments the strobe count.
  - When the count reaches the latched burst, clear pg_start on the following edge and go to DRAIN.
  - pg_start stays high between periods, so periods run back-to-back with no idle gap.
- DRAIN
  - Wait for pg_busy == 0.
  - Then pulse done[owner] for 1 cycle, clear gnt, set rr_ptr = owner+1 (mod N_CH), go to IDLE.

Timing and latency:
- req to first pg_start: 2 cycles (IDLE→CHECK→RUN).
- Last strobe to done: the remaining period length plus 2 cycles.

Requester rules:
- req is level-sensitive. A requester must drop req in the done cycle, or it re-enters arbitration.
- Round-robin guarantees every pending channel is granted within N_CH grants.
- ch_* inputs may change at any time. Only the values latched at the IDLE→CHECK transition are used.
- req deasserted during a granted burst is ignored; the burst completes.
- The strobe count is BURST_WIDTH bits and never wraps, because comparison is exact and burst ≥ 1.
- pg_start_strobe seen in IDLE, CHECK or DRAIN is ignored.

Optional Feature:
- Macro: PULSE_SCHED_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest channel index wins; rr_ptr is removed.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package pulse_sched_pkg holds:
  - state enum type sched_state_t (IDLE, CHECK, RUN, DRAIN);
  - localparam function for the wrap-around round-robin pick.
- One sub-module is natural: rr_arbiter, parameterised on N_CH.
  - Inputs: req and ptr. Output: one-hot grant.
  - Under PULSE_SCHED_FIXED_PRIO_EN it degenerates to a priority encoder.
- pulse_gen is instantiated by the parent, not inside pulse_sched.

Test Plan:
- Single channel, ch0: max=4, low=2, burst=3 → 3 back-to-back periods of 5 cycles, each HIGH for 3 cycles. Exactly 3 strobes, one done[0], err=0.
- Illegal requests:
  - ch1 burst=0 → done[1] and err in the CHECK cycle; pg_start never asserts.
  - ch2 cntr_max=0 → same response.
- Contention: req=4'b1111 held, each channel drops req on its done → grant order 0,1,2,3. Second run with rr_ptr=2 → order 2,3,0,1.
- ch_cntr_max changed from 4 to 9 mid-burst → all periods stay 5 cycles long.
- nrst pulsed low in RUN during the 2nd period → pg_start, gnt and sched_busy drop asynchronously; no done. After release, pending req is re-arbitrated from ptr 0.
- en held low 10 cycles during DRAIN → state and gnt frozen. done is issued only after en returns and pg_busy is low.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types and arbitration helpers for pulse_sched.
// Latency/backpressure: none (types and pure functions only).
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  // Distance of channel ch from the round-robin pointer, wrapping at n.
  function automatic int unsigned rr_dist(input int unsigned ch,
                                          input int unsigned ptr,
                                          input int unsigned n);
    return (ch + n - ptr) % n;
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arbiter.sv
// One-hot arbiter: wrap-around round-robin from ptr_i, or lowest-index priority when
// PULSE_SCHED_FIXED_PRIO_EN is defined. Combinational, no backpressure.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_CH-1:0]  req_i,
`ifndef PULSE_SCHED_FIXED_PRIO_EN
  input  logic [PTR_W-1:0] ptr_i,
`endif
  output logic [N_CH-1:0]  gnt_o
);

`ifdef PULSE_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_o = '0;
    for (int c = int'(N_CH) - 1; c >= 0; c--) begin
      if (req_i[c]) begin
        gnt_o    = '0;
        gnt_o[c] = 1'b1;
      end
    end
  end
`else
  int unsigned best;

  // Keep the set requester closest to the pointer (strictly smaller distance wins).
  always_comb begin
    gnt_o = '0;
    best  = N_CH;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (req_i[c] && (rr_dist(c, 32'(ptr_i), N_CH) < best)) begin
        best     = rr_dist(c, 32'(ptr_i), N_CH);
        gnt_o    = '0;
        gnt_o[c] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pulse_sched.sv
// Shares one pulse_gen between N_CH requesters; req to first pg_start is 2 cycles, last strobe
// to done is remaining period + 2. en_i low freezes everything. PULSE_SCHED_FIXED_PRIO_EN selects fixed priority.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNTR_WIDTH  = 32,
  parameter int unsigned BURST_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        nrst_i,
  input  logic                        en_i,
  input  logic [N_CH-1:0]             req_i,
  input  logic [N_CH*CNTR_WIDTH-1:0]  ch_cntr_max_i,
  input  logic [N_CH*CNTR_WIDTH-1:0]  ch_cntr_low_i,
  input  logic [N_CH*BURST_WIDTH-1:0] ch_burst_i,
  output logic [N_CH-1:0]             gnt_o,
  output logic [N_CH-1:0]             done_o,
  output logic                        err_o,
  output logic                        pg_start_o,
  output logic [CNTR_WIDTH-1:0]       pg_cntr_max_o,
  output logic [CNTR_WIDTH-1:0]       pg_cntr_low_o,
  input  logic                        pg_start_strobe_i,
  input  logic                        pg_busy_i,
  output logic                        sched_busy_o
);

  localparam int unsigned PTR_W = $clog2(N_CH);

  sched_state_t           state_q, state_d;
  logic [N_CH-1:0]        gnt_q, gnt_d;
  logic [N_CH-1:0]        done_q, done_d;
  logic                   err_q, err_d;
  logic                   pg_start_q, pg_start_d;
  logic [CNTR_WIDTH-1:0]  pg_max_q, pg_max_d;
  logic [CNTR_WIDTH-1:0]  pg_low_q, pg_low_d;
  logic [CNTR_WIDTH-1:0]  lat_max_q, lat_max_d;
  logic [CNTR_WIDTH-1:0]  lat_low_q, lat_low_d;
  logic [BURST_WIDTH-1:0] lat_burst_q, lat_burst_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic [BURST_WIDTH-1:0] cnt_inc;

  logic [N_CH-1:0]        arb_gnt;
  logic [CNTR_WIDTH-1:0]  sel_max, sel_low;
  logic [BURST_WIDTH-1:0] sel_burst;

`ifndef PULSE_SCHED_FIXED_PRIO_EN
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       win_idx;

  rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_arb (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (arb_gnt[c]) win_idx = PTR_W'(c);
    end
  end
`else
  rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_arb (
    .req_i (req_i),
    .gnt_o (arb_gnt)
  );
`endif

  always_comb begin
    sel_max   = '0;
    sel_low   = '0;
    sel_burst = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (arb_gnt[c]) begin
        sel_max   = ch_cntr_max_i[c*CNTR_WIDTH +: CNTR_WIDTH];
        sel_low   = ch_cntr_low_i[c*CNTR_WIDTH +: CNTR_WIDTH];
        sel_burst = ch_burst_i[c*BURST_WIDTH +: BURST_WIDTH];
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    pg_start_d  = pg_start_q;
    pg_max_d    = pg_max_q;
    pg_low_d    = pg_low_q;
    lat_max_d   = lat_max_q;
    lat_low_d   = lat_low_q;
    lat_burst_d = lat_burst_q;
    cnt_d       = cnt_q;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d       = arb_gnt;
          lat_max_d   = sel_max;
          lat_low_d   = sel_low;
          lat_burst_d = sel_burst;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
          owner_d     = win_idx;
`endif
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if ((lat_burst_q == '0) || (lat_max_q == '0)) begin
          // Rejected requests never touch pulse_gen and do not advance the pointer.
          done_d  = gnt_q;
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          pg_max_d   = lat_max_q;
          pg_low_d   = lat_low_q;
          pg_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (pg_start_strobe_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == lat_burst_q) begin
            pg_start_d = 1'b0;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!pg_busy_i) begin
          done_d  = gnt_q;
          gnt_d   = '0;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
          rr_ptr_d = (owner_q == PTR_W'(N_CH - 1)) ? '0 : owner_q + 1'b1;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      pg_start_q  <= 1'b0;
      pg_max_q    <= '0;
      pg_low_q    <= '0;
      lat_max_q   <= '0;
      lat_low_q   <= '0;
      lat_burst_q <= '0;
      cnt_q       <= '0;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
      owner_q     <= '0;
`endif
    end else if (en_i) begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pg_start_q  <= pg_start_d;
      pg_max_q    <= pg_max_d;
      pg_low_q    <= pg_low_d;
      lat_max_q   <= lat_max_d;
      lat_low_q   <= lat_low_d;
      lat_burst_q <= lat_burst_d;
      cnt_q       <= cnt_d;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign pg_start_o    = pg_start_q;
  assign pg_cntr_max_o = pg_max_q;
  assign pg_cntr_low_o = pg_low_q;
  assign sched_busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_sched.sv
// Scoreboard bench for pulse_sched with a behavioural pulse_gen and a round-robin reference model.
module tb_pulse_sched;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            nrst;
  logic            en_i;
  logic [N-1:0]    req_i;
  logic [N*CW-1:0] ch_cntr_max_i;
  logic [N*CW-1:0] ch_cntr_low_i;
  logic [N*BW-1:0] ch_burst_i;
  logic [N-1:0]    gnt_o, done_o;
  logic            err_o, pg_start_o, sched_busy_o;
  logic [CW-1:0]   pg_cntr_max_o, pg_cntr_low_o;
  logic            pg_strobe, pg_busy;
  logic [CW-1:0]   pg_cnt;

  always #5 clk = ~clk;

  pulse_sched #(.N_CH(N), .CNTR_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .clk_i             (clk),
    .nrst_i            (nrst),
    .en_i              (en_i),
    .req_i             (req_i),
    .ch_cntr_max_i     (ch_cntr_max_i),
    .ch_cntr_low_i     (ch_cntr_low_i),
    .ch_burst_i        (ch_burst_i),
    .gnt_o             (gnt_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .pg_start_o        (pg_start_o),
    .pg_cntr_max_o     (pg_cntr_max_o),
    .pg_cntr_low_o     (pg_cntr_low_o),
    .pg_start_strobe_i (pg_strobe),
    .pg_busy_i         (pg_busy),
    .sched_busy_o      (sched_busy_o)
  );

  // Behavioural pulse_gen: period of cntr_max+1 cycles, strobe at each period start, restarts while start is high.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pg_busy   <= 1'b0;
      pg_cnt    <= '0;
      pg_strobe <= 1'b0;
    end else if (!pg_busy || pg_cnt == pg_cntr_max_o) begin
      if (pg_start_o) begin
        pg_busy   <= 1'b1;
        pg_cnt    <= '0;
        pg_strobe <= 1'b1;
      end else begin
        pg_busy   <= 1'b0;
        pg_strobe <= 1'b0;
      end
    end else begin
      pg_cnt    <= pg_cnt + 1;
      pg_strobe <= 1'b0;
    end
  end

  typedef struct {
    int ch;
    bit err;
    int strobes;
    int period;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mptr   = 0;
  int   cmax[N], clow[N], cburst[N];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic pack_cfg();
    for (int c = 0; c < N; c++) begin
      ch_cntr_max_i[c*CW +: CW] = cmax[c];
      ch_cntr_low_i[c*CW +: CW] = clow[c];
      ch_burst_i[c*BW +: BW]    = cburst[c][BW-1:0];
    end
  endtask

  // Reference: grant order is repeated "nearest pending channel at or after the pointer";
  // only accepted requests move the pointer past the owner.
  task automatic push_expected(input logic [N-1:0] mask);
    logic [N-1:0] m;
    exp_t e;
    int c;
    m = mask;
    while (m != 0) begin
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (m[c]) begin
          e.ch      = c;
          e.err     = (cburst[c] == 0) || (cmax[c] == 0);
          e.strobes = e.err ? 0 : cburst[c];
          e.period  = cmax[c] + 1;
          sb_q.push_back(e);
          m[c] = 1'b0;
          if (!e.err) mptr = (c + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic wait_clear(input int mod_cycle);
    int t;
    t = 0;
    while (req_i != 0 && t < 4000) begin
      @(negedge clk);
      t++;
      if (done_o != 0) req_i = req_i & ~done_o;
      if (t == mod_cycle) begin
        for (int c = 0; c < N; c++) cmax[c] = 9;
        pack_cfg();
      end
    end
    check("round_completes", longint'(req_i), 0);
    t = 0;
    while (sched_busy_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic issue_round(input logic [N-1:0] mask, input int mod_cycle);
    pack_cfg();
    push_expected(mask);
    req_i = mask;
    wait_clear(mod_cycle);
  endtask

  task automatic monitor();
    int cyc = 0, last = 0, nstb = 0, gmin = 0, gmax = 0, gap;
    bit active = 0, pg_seen = 0;
    logic [N-1:0] seen_gnt = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) begin
        active = 0;
      end else begin
        if (gnt_o != 0 && !active) begin
          active = 1; seen_gnt = gnt_o; nstb = 0; pg_seen = 0;
          gmin = 1000000; gmax = 0;
        end
        if (active) begin
          if (pg_start_o) pg_seen = 1;
          if (pg_strobe) begin
            if (nstb > 0) begin
              gap = cyc - last;
              if (gap < gmin) gmin = gap;
              if (gap > gmax) gmax = gap;
            end
            last = cyc;
            nstb++;
          end
        end
        if (done_o != 0) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: done=%b with nothing expected", done_o);
          end else begin
            e = sb_q.pop_front();
            check("done_channel", longint'(done_o), longint'(1) << e.ch);
            check("grant_channel", longint'(seen_gnt), longint'(1) << e.ch);
            check("err_flag", longint'(err_o), longint'(e.err));
            check("strobe_count", nstb, e.strobes);
            check("pg_start_used", longint'(pg_seen), longint'(!e.err));
            if (e.strobes >= 2) begin
              check("period_min", gmin, e.period);
              check("period_max", gmax, e.period);
            end
          end
          active = 0;
        end
      end
    end
  endtask

  initial begin
    int t, nst;
    bit saw_start, frozen;
    logic [N-1:0] g;
    nrst  = 1'b0;
    en_i  = 1'b1;
    req_i = '0;
    for (int c = 0; c < N; c++) begin
      cmax[c] = 0; clow[c] = 0; cburst[c] = 0;
    end
    pack_cfg();
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_gnt", longint'(gnt_o), 0);
    check("rst_done", longint'(done_o), 0);
    check("rst_err", longint'(err_o), 0);
    check("rst_pg_start", longint'(pg_start_o), 0);
    check("rst_pg_max", longint'(pg_cntr_max_o), 0);
    check("rst_pg_low", longint'(pg_cntr_low_o), 0);
    check("rst_sched_busy", longint'(sched_busy_o), 0);
    nrst = 1'b1;
    @(negedge clk);

    // Contention from pointer 0, then from pointer 2.
    for (int c = 0; c < N; c++) begin
      cmax[c] = 3; clow[c] = 1; cburst[c] = 2;
    end
    issue_round(4'b1111, 0);
    issue_round(4'b0010, 0);
    issue_round(4'b1111, 0);

    // Single channel burst with latency check and mid-burst config change.
    cmax[0] = 4; clow[0] = 2; cburst[0] = 3;
    pack_cfg();
    push_expected(4'b0001);
    req_i = 4'b0001;
    @(negedge clk);
    check("check_state_no_start", longint'(pg_start_o), 0);
    check("check_state_gnt", longint'(gnt_o), 1);
    @(negedge clk);
    check("req_to_start_2cyc", longint'(pg_start_o), 1);
    check("pg_max_driven", longint'(pg_cntr_max_o), 4);
    check("pg_low_driven", longint'(pg_cntr_low_o), 2);
    wait_clear(6);

    // Illegal requests.
    cmax[1] = 5; clow[1] = 1; cburst[1] = 0;
    issue_round(4'b0010, 0);
    cmax[2] = 0; clow[2] = 0; cburst[2] = 2;
    issue_round(4'b0100, 0);

    // Randomised rounds.
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < N; c++) begin
        cmax[c]   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
        clow[c]   = int'($urandom_range(0, cmax[c]));
        cburst[c] = int'($urandom_range(0, 4));
      end
      issue_round(4'($urandom_range(1, 15)), 0);
    end

    // Reset during the second period of a burst.
    cmax[2] = 2; clow[2] = 1; cburst[2] = 1;
    issue_round(4'b0100, 0);
    cmax[3] = 4; clow[3] = 2; cburst[3] = 3;
    cmax[1] = 2; clow[1] = 1; cburst[1] = 2;
    pack_cfg();
    req_i = 4'b1010;
    nst = 0; t = 0;
    while (nst < 2 && t < 200) begin
      @(negedge clk);
      t++;
      if (pg_strobe) nst++;
    end
    check("reach_second_period", nst, 2);
    check("rr_winner_before_reset", longint'(gnt_o), 4'b1000);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_pg_start", longint'(pg_start_o), 0);
    check("async_rst_gnt", longint'(gnt_o), 0);
    check("async_rst_sched_busy", longint'(sched_busy_o), 0);
    sb_q.delete();
    mptr = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_no_done", longint'(done_o), 0);
    nrst = 1'b1;
    push_expected(4'b1010);
    wait_clear(0);

    // en low for 10 cycles during DRAIN.
    cmax[0] = 6; clow[0] = 2; cburst[0] = 1;
    pack_cfg();
    push_expected(4'b0001);
    req_i = 4'b0001;
    saw_start = 0; t = 0;
    while (t < 100 && !(saw_start && !pg_start_o)) begin
      @(negedge clk);
      t++;
      if (pg_start_o) saw_start = 1;
    end
    check("reach_drain", longint'(saw_start && !pg_start_o && sched_busy_o), 1);
    en_i = 1'b0;
    g = gnt_o;
    frozen = 1;
    repeat (10) begin
      @(negedge clk);
      if (gnt_o != g || !sched_busy_o || done_o != 0) frozen = 0;
    end
    check("en_low_frozen", longint'(frozen), 1);
    check("pg_idle_while_frozen", longint'(pg_busy), 0);
    en_i = 1'b1;
    @(negedge clk);
    check("done_after_en", longint'(done_o), 1);
    req_i = '0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained_en", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
